// File: rtl/noc_packetizer.sv
// Packetizer: descriptor + body words -> flits on a round-robin VC; 1-cycle registered flit output.
// Backpressure: pkt_ready_o needs a fully drained VC, body_ready_o needs a credit on the packet's VC.
package noc_params;
  localparam int VC_NUM            = 4;
  localparam int VC_SIZE           = $clog2(VC_NUM);
  localparam int DEST_ADDR_SIZE_X  = 4;
  localparam int DEST_ADDR_SIZE_Y  = 4;
  localparam int DEST_ADDR_SIZE_L  = 1;
  localparam int HEAD_PAYLOAD_SIZE = 128;
  localparam int FLIT_DATA_SIZE    = 137;

  typedef enum logic [1:0] {HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, HEADTAIL = 2'b11} flit_label_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [DEST_ADDR_SIZE_L-1:0]  l_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  typedef union packed {
    head_data_t                head_data;
    logic [FLIT_DATA_SIZE-1:0] bt_pl;
  } flit_data_t;

  typedef struct packed {
    flit_label_t        flit_label;
    logic [VC_SIZE-1:0] vc_id;
    flit_data_t         data;
  } flit_t;
endpackage

module noc_packetizer
  import noc_params::*;
#(
  parameter int BUFFER_DEPTH = 4,
  parameter int BODY_LEN_W   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pkt_valid_i,
  output logic                         pkt_ready_o,
  input  logic [DEST_ADDR_SIZE_X-1:0]  pkt_x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0]  pkt_y_dest_i,
  input  logic [DEST_ADDR_SIZE_L-1:0]  pkt_l_dest_i,
  input  logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i,
  input  logic [BODY_LEN_W-1:0]        pkt_body_len_i,
  input  logic                         body_valid_i,
  output logic                         body_ready_o,
  input  logic [FLIT_DATA_SIZE-1:0]    body_data_i,
  output logic                         flit_valid_o,
  output logic [$bits(flit_t)-1:0]     flit_o,
  input  logic [VC_NUM-1:0]            credit_i,
  output logic                         credit_err_o
);
  localparam int CW = $clog2(BUFFER_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(BUFFER_DEPTH);

  typedef enum logic {ST_IDLE, ST_BODY} state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_credit [VC_NUM];
  logic                  r_credit_err;
  logic [VC_SIZE-1:0]    r_last_vc, r_vc;
  logic [BODY_LEN_W-1:0] r_remaining;
  flit_t                 r_flit, w_flit_nxt;
  logic                  r_flit_vld;

  logic [VC_NUM-1:0]  w_eligible, w_commit;
  logic               w_any_eligible, w_found, w_credit_avail;
  logic [VC_SIZE-1:0] w_sel_vc, w_idx;
  logic               w_pkt_hs, w_body_hs;

  always_comb begin
    for (int v = 0; v < VC_NUM; v++) w_eligible[v] = (r_credit[v] == FULL);
  end
  assign w_any_eligible = |w_eligible;
  assign w_credit_avail = (r_credit[r_vc] != '0);

  // First eligible VC at or after last_vc+1; index wraps naturally at VC_SIZE bits.
  always_comb begin
    w_sel_vc = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      w_idx = r_last_vc + VC_SIZE'(i + 1);
      if (!w_found && w_eligible[w_idx]) begin
        w_sel_vc = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_pkt_hs && pkt_body_len_i != '0) w_state_nxt = ST_BODY;
      ST_BODY: if (w_body_hs && r_remaining == BODY_LEN_W'(1)) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    pkt_ready_o  = (r_state == ST_IDLE) && w_any_eligible;
    body_ready_o = (r_state == ST_BODY) && w_credit_avail;
  end

  assign w_pkt_hs  = pkt_valid_i && pkt_ready_o;
  assign w_body_hs = body_valid_i && body_ready_o;

  always_comb begin
    for (int v = 0; v < VC_NUM; v++)
      w_commit[v] = (w_pkt_hs && w_sel_vc == VC_SIZE'(v)) || (w_body_hs && r_vc == VC_SIZE'(v));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < VC_NUM; v++) r_credit[v] <= FULL;
      r_credit_err <= 1'b0;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        case ({w_commit[v], credit_i[v]})
          2'b10: r_credit[v] <= r_credit[v] - 1'b1;
          2'b01: begin
            if (r_credit[v] == FULL) r_credit_err <= 1'b1;
            else                     r_credit[v]  <= r_credit[v] + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_flit_nxt = r_flit;
    if (w_pkt_hs) begin
      w_flit_nxt.flit_label             = (pkt_body_len_i == '0) ? HEADTAIL : HEAD;
      w_flit_nxt.vc_id                  = w_sel_vc;
      w_flit_nxt.data.head_data.x_dest  = pkt_x_dest_i;
      w_flit_nxt.data.head_data.y_dest  = pkt_y_dest_i;
      w_flit_nxt.data.head_data.l_dest  = pkt_l_dest_i;
      w_flit_nxt.data.head_data.head_pl = pkt_head_pl_i;
    end else if (w_body_hs) begin
      w_flit_nxt.flit_label = (r_remaining == BODY_LEN_W'(1)) ? TAIL : BODY;
      w_flit_nxt.vc_id      = r_vc;
      w_flit_nxt.data.bt_pl = body_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flit      <= '0;
      r_flit_vld  <= 1'b0;
      r_vc        <= '0;
      r_last_vc   <= VC_SIZE'(VC_NUM - 1);
      r_remaining <= '0;
    end else begin
      r_flit     <= w_flit_nxt;
      r_flit_vld <= w_pkt_hs || w_body_hs;
      if (w_pkt_hs) begin
        r_vc        <= w_sel_vc;
        r_last_vc   <= w_sel_vc;
        r_remaining <= pkt_body_len_i;
      end else if (w_body_hs) begin
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  assign flit_o       = r_flit;
  assign flit_valid_o = r_flit_vld;
  assign credit_err_o = r_credit_err;

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed bench for noc_packetizer: reset, HEADTAIL, multi-flit, credit stall, VC exhaustion, credit boundaries.
module tb_noc_packetizer;
  import noc_params::*;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         pkt_valid_i;
  logic                         pkt_ready_o;
  logic [DEST_ADDR_SIZE_X-1:0]  pkt_x_dest_i;
  logic [DEST_ADDR_SIZE_Y-1:0]  pkt_y_dest_i;
  logic [DEST_ADDR_SIZE_L-1:0]  pkt_l_dest_i;
  logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i;
  logic [3:0]                   pkt_body_len_i;
  logic                         body_valid_i;
  logic                         body_ready_o;
  logic [FLIT_DATA_SIZE-1:0]    body_data_i;
  logic                         flit_valid_o;
  logic [$bits(flit_t)-1:0]     flit_o;
  logic [VC_NUM-1:0]            credit_i;
  logic                         credit_err_o;

  int    tests_run    = 0;
  int    tests_failed = 0;
  flit_t got;

  localparam logic [127:0] PL1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
  localparam logic [127:0] PL2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [136:0] DA  = 137'h1_AAAA_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [136:0] DB  = 137'h0_BBBB_0000_0000_0000_0000_0000_0000_0002;

  noc_packetizer #(.BUFFER_DEPTH(4), .BODY_LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
    .pkt_x_dest_i(pkt_x_dest_i), .pkt_y_dest_i(pkt_y_dest_i), .pkt_l_dest_i(pkt_l_dest_i),
    .pkt_head_pl_i(pkt_head_pl_i), .pkt_body_len_i(pkt_body_len_i),
    .body_valid_i(body_valid_i), .body_ready_o(body_ready_o), .body_data_i(body_data_i),
    .flit_valid_o(flit_valid_o), .flit_o(flit_o),
    .credit_i(credit_i), .credit_err_o(credit_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
    got = flit_o;
  endtask

  task automatic idle_inputs;
    pkt_valid_i = 0; pkt_x_dest_i = '0; pkt_y_dest_i = '0; pkt_l_dest_i = '0;
    pkt_head_pl_i = '0; pkt_body_len_i = '0; body_valid_i = 0; body_data_i = '0; credit_i = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
  endtask

  task automatic drive_desc(input logic [3:0] x, input logic [3:0] y, input logic l,
                            input logic [127:0] pl, input logic [3:0] len);
    pkt_valid_i = 1; pkt_x_dest_i = x; pkt_y_dest_i = y; pkt_l_dest_i = l;
    pkt_head_pl_i = pl; pkt_body_len_i = len;
  endtask

  task automatic test_reset;
    do_reset();
    drive_desc(4'd5, 4'd6, 1'b0, PL2, 4'd3);
    tick();
    pkt_valid_i = 0; body_valid_i = 1; body_data_i = DA;
    tick();
    body_valid_i = 0;
    rst_n = 0;
    #2;
    tests_run++; if (flit_valid_o !== 1'b0) begin tests_failed++; $display("FAIL rst_flit_valid: got %0b want 0", flit_valid_o); end
    tests_run++; if (flit_o !== '0) begin tests_failed++; $display("FAIL rst_flit_o: got %0h want 0", flit_o); end
    tests_run++; if (credit_err_o !== 1'b0) begin tests_failed++; $display("FAIL rst_credit_err: got %0b want 0", credit_err_o); end
    tests_run++; if (pkt_ready_o !== 1'b1) begin tests_failed++; $display("FAIL rst_pkt_ready: got %0b want 1", pkt_ready_o); end
    tests_run++; if (body_ready_o !== 1'b0) begin tests_failed++; $display("FAIL rst_body_ready: got %0b want 0", body_ready_o); end
    tick();
    rst_n = 1;
    drive_desc(4'd2, 4'd3, 1'b1, PL1, 4'd0);
    tests_run++; if (pkt_ready_o !== 1'b1) begin tests_failed++; $display("FAIL post_rst_pkt_ready: got %0b want 1", pkt_ready_o); end
    tick();
    pkt_valid_i = 0;
    tests_run++; if (flit_valid_o !== 1'b1) begin tests_failed++; $display("FAIL post_rst_flit_valid: got %0b want 1", flit_valid_o); end
    tests_run++; if (got.vc_id !== 2'd0) begin tests_failed++; $display("FAIL post_rst_vc: got %0d want 0", got.vc_id); end
  endtask

  task automatic test_headtail;
    logic [140:0] exp;
    do_reset();
    exp = {HEADTAIL, 2'd0, 4'd2, 4'd3, 1'b1, PL1};
    drive_desc(4'd2, 4'd3, 1'b1, PL1, 4'd0);
    tests_run++; if (pkt_ready_o !== 1'b1) begin tests_failed++; $display("FAIL ht_pkt_ready: got %0b want 1", pkt_ready_o); end
    tick();
    pkt_valid_i = 0;
    tests_run++; if (flit_valid_o !== 1'b1) begin tests_failed++; $display("FAIL ht_flit_valid: got %0b want 1", flit_valid_o); end
    tests_run++; if (flit_o !== exp) begin tests_failed++; $display("FAIL ht_flit: got %0h want %0h", flit_o, exp); end
    tests_run++; if (dut.r_credit[0] !== 3'd3) begin tests_failed++; $display("FAIL ht_cnt_dec: got %0d want 3", dut.r_credit[0]); end
    credit_i = 4'b0001;
    tick();
    credit_i = '0;
    tests_run++; if (flit_valid_o !== 1'b0) begin tests_failed++; $display("FAIL ht_no_flit: got %0b want 0", flit_valid_o); end
    tests_run++; if (dut.r_credit[0] !== 3'd4) begin tests_failed++; $display("FAIL ht_cnt_ret: got %0d want 4", dut.r_credit[0]); end
  endtask

  task automatic test_three_flit;
    logic [140:0] exp;
    do_reset();
    exp = {HEAD, 2'd0, 4'd1, 4'd2, 1'b0, PL2};
    drive_desc(4'd1, 4'd2, 1'b0, PL2, 4'd2);
    tick();
    pkt_valid_i = 0;
    tests_run++; if (flit_o !== exp || flit_valid_o !== 1'b1) begin tests_failed++; $display("FAIL p3_head: got %0h/%0b want %0h/1", flit_o, flit_valid_o, exp); end
    body_valid_i = 1; body_data_i = DA;
    tests_run++; if (body_ready_o !== 1'b1) begin tests_failed++; $display("FAIL p3_body_ready: got %0b want 1", body_ready_o); end
    tick();
    body_data_i = DB;
    tests_run++; if (flit_valid_o !== 1'b1 || got.flit_label !== BODY || got.vc_id !== 2'd0 || got.data.bt_pl !== DA) begin
      tests_failed++; $display("FAIL p3_body: got v=%0b lbl=%0d vc=%0d pl=%0h want v=1 lbl=1 vc=0 pl=%0h", flit_valid_o, got.flit_label, got.vc_id, got.data.bt_pl, DA); end
    tick();
    body_valid_i = 0;
    tests_run++; if (flit_valid_o !== 1'b1 || got.flit_label !== TAIL || got.vc_id !== 2'd0 || got.data.bt_pl !== DB) begin
      tests_failed++; $display("FAIL p3_tail: got v=%0b lbl=%0d vc=%0d pl=%0h want v=1 lbl=2 vc=0 pl=%0h", flit_valid_o, got.flit_label, got.vc_id, got.data.bt_pl, DB); end
    drive_desc(4'd3, 4'd3, 1'b1, PL1, 4'd0);
    tests_run++; if (pkt_ready_o !== 1'b1) begin tests_failed++; $display("FAIL p3_next_ready: got %0b want 1", pkt_ready_o); end
    tick();
    pkt_valid_i = 0;
    tests_run++; if (flit_valid_o !== 1'b1 || got.vc_id !== 2'd1 || got.flit_label !== HEADTAIL) begin
      tests_failed++; $display("FAIL p3_next_vc: got v=%0b vc=%0d lbl=%0d want v=1 vc=1 lbl=3", flit_valid_o, got.vc_id, got.flit_label); end
  endtask

  task automatic test_credit_stall;
    do_reset();
    drive_desc(4'd0, 4'd1, 1'b0, PL1, 4'd6);
    tick();
    pkt_valid_i = 0;
    body_valid_i = 1;
    for (int i = 0; i < 3; i++) begin
      body_data_i = FLIT_DATA_SIZE'(i + 1);
      tick();
    end
    tests_run++; if (flit_valid_o !== 1'b1 || body_ready_o !== 1'b0) begin
      tests_failed++; $display("FAIL cs_stall: got v=%0b rdy=%0b want v=1 rdy=0", flit_valid_o, body_ready_o); end
    body_data_i = DB;
    tick();
    tests_run++; if (flit_valid_o !== 1'b0 || body_ready_o !== 1'b0) begin
      tests_failed++; $display("FAIL cs_held: got v=%0b rdy=%0b want v=0 rdy=0", flit_valid_o, body_ready_o); end
    credit_i = 4'b0001;
    tick();
    credit_i = '0;
    tests_run++; if (body_ready_o !== 1'b1 || flit_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL cs_credit_ready: got rdy=%0b v=%0b want rdy=1 v=0", body_ready_o, flit_valid_o); end
    tick();
    tests_run++; if (flit_valid_o !== 1'b1 || got.flit_label !== BODY || got.data.bt_pl !== DB || body_ready_o !== 1'b0) begin
      tests_failed++; $display("FAIL cs_one_more: got v=%0b lbl=%0d pl=%0h rdy=%0b want v=1 lbl=1 pl=%0h rdy=0", flit_valid_o, got.flit_label, got.data.bt_pl, body_ready_o, DB); end
    tick();
    body_valid_i = 0;
    tests_run++; if (flit_valid_o !== 1'b0) begin tests_failed++; $display("FAIL cs_only_one: got %0b want 0", flit_valid_o); end
  endtask

  task automatic test_vc_exhaust;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_desc(4'(i), 4'd0, 1'b0, PL2, 4'd0);
      tests_run++; if (pkt_ready_o !== 1'b1) begin tests_failed++; $display("FAIL ex_ready_%0d: got %0b want 1", i, pkt_ready_o); end
      tick();
      pkt_valid_i = 0;
      tests_run++; if (flit_valid_o !== 1'b1 || got.vc_id !== 2'(i)) begin
        tests_failed++; $display("FAIL ex_vc_%0d: got v=%0b vc=%0d want v=1 vc=%0d", i, flit_valid_o, got.vc_id, i); end
    end
    tests_run++; if (pkt_ready_o !== 1'b0) begin tests_failed++; $display("FAIL ex_exhausted: got %0b want 0", pkt_ready_o); end
    credit_i = 4'b0100;
    tick();
    credit_i = '0;
    drive_desc(4'd7, 4'd7, 1'b1, PL1, 4'd0);
    tests_run++; if (pkt_ready_o !== 1'b1) begin tests_failed++; $display("FAIL ex_vc2_ready: got %0b want 1", pkt_ready_o); end
    tick();
    pkt_valid_i = 0;
    tests_run++; if (flit_valid_o !== 1'b1 || got.vc_id !== 2'd2) begin
      tests_failed++; $display("FAIL ex_vc2: got v=%0b vc=%0d want v=1 vc=2", flit_valid_o, got.vc_id); end
  endtask

  task automatic test_boundary;
    do_reset();
    drive_desc(4'd1, 4'd1, 1'b1, PL2, 4'd2);
    tick();
    pkt_valid_i = 0;
    body_valid_i = 1; body_data_i = DA; credit_i = 4'b0001;
    tick();
    body_valid_i = 0; credit_i = 4'b0010;
    tests_run++; if (dut.r_credit[0] !== 3'd3) begin tests_failed++; $display("FAIL bd_same_cycle: got %0d want 3", dut.r_credit[0]); end
    tests_run++; if (flit_valid_o !== 1'b1 || got.flit_label !== BODY) begin
      tests_failed++; $display("FAIL bd_body: got v=%0b lbl=%0d want v=1 lbl=1", flit_valid_o, got.flit_label); end
    tests_run++; if (credit_err_o !== 1'b0) begin tests_failed++; $display("FAIL bd_err_clear: got %0b want 0", credit_err_o); end
    tick();
    credit_i = '0;
    tests_run++; if (credit_err_o !== 1'b1) begin tests_failed++; $display("FAIL bd_err_set: got %0b want 1", credit_err_o); end
    tests_run++; if (dut.r_credit[1] !== 3'd4) begin tests_failed++; $display("FAIL bd_cnt_sat: got %0d want 4", dut.r_credit[1]); end
    tick();
    tests_run++; if (credit_err_o !== 1'b1) begin tests_failed++; $display("FAIL bd_err_sticky: got %0b want 1", credit_err_o); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_headtail();
    test_three_flit();
    test_credit_stall();
    test_vc_exhaust();
    test_boundary();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
